// File: rtl/sata_prim_pkg.sv
// SATA link-layer primitive codes and their 32-bit encodings, shared by the transmit path.
package sata_prim_pkg;

    typedef enum logic [3:0] {
        SYNC  = 4'd0,
        HOLD  = 4'd1,
        HOLDA = 4'd2,
        R_RDY = 4'd3,
        X_RDY = 4'd4,
        R_IP  = 4'd5,
        R_OK  = 4'd6,
        R_ERR = 4'd7,
        WTRM  = 4'd8,
        SOF   = 4'd9,
        EOF   = 4'd10,
        DATA  = 4'd11
    } prim_code_t;

    localparam logic [3:0]  PRIM_K     = 4'b0001;
    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] PRIM_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] PRIM_HOLDA = 32'h9595AA7C;
    localparam logic [31:0] PRIM_R_RDY = 32'h4A4A957C;
    localparam logic [31:0] PRIM_X_RDY = 32'h5757B57C;
    localparam logic [31:0] PRIM_R_IP  = 32'h5555B57C;
    localparam logic [31:0] PRIM_R_OK  = 32'h3535B57C;
    localparam logic [31:0] PRIM_R_ERR = 32'h5656B57C;
    localparam logic [31:0] PRIM_WTRM  = 32'h5858B57C;
    localparam logic [31:0] PRIM_SOF   = 32'h3737B57C;
    localparam logic [31:0] PRIM_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] PRIM_CONT  = 32'h9999AA7C;

    // Codes above DATA are unassigned and fall back to SYNC.
    function automatic prim_code_t norm_code(input logic [3:0] code);
        return (code > 4'd11) ? SYNC : prim_code_t'(code);
    endfunction

    function automatic logic [31:0] prim_dword(input prim_code_t code);
        logic [31:0] dw;
        case (code)
            HOLD:    dw = PRIM_HOLD;
            HOLDA:   dw = PRIM_HOLDA;
            R_RDY:   dw = PRIM_R_RDY;
            X_RDY:   dw = PRIM_X_RDY;
            R_IP:    dw = PRIM_R_IP;
            R_OK:    dw = PRIM_R_OK;
            R_ERR:   dw = PRIM_R_ERR;
            WTRM:    dw = PRIM_WTRM;
            SOF:     dw = PRIM_SOF;
            EOF:     dw = PRIM_EOF;
            default: dw = PRIM_SYNC;
        endcase
        return dw;
    endfunction

    function automatic logic is_repeatable(input prim_code_t code);
        return code <= WTRM;
    endfunction

endpackage

// File: rtl/sata_junk_lfsr.sv
// Junk-dword generator for CONT runs (built only with SATA_TX_CONT_EN).
// 16-bit Fibonacci LFSR x^16+x^15+x^13+x^4+1; each step yields two 16-bit states as one dword.
module sata_junk_lfsr (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        advance,
    output logic [31:0] junk
);
    localparam logic [15:0] SEED = 16'hF0F6;

    logic [15:0] lfsr_q;
    logic [15:0] s1;
    logic [15:0] s2;

    function automatic logic [15:0] step16(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 16; i++) begin
            r = {r[14:0], r[15] ^ r[14] ^ r[12] ^ r[3]};
        end
        return r;
    endfunction

    assign s1   = step16(lfsr_q);
    assign s2   = step16(s1);
    assign junk = {s2, s1};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lfsr_q <= SEED;
        end else if (advance) begin
            lfsr_q <= s2;
        end
    end

endmodule

// File: rtl/sata_link_tx_prim.sv
// Link-layer transmit dword generator: primitives, payload pass-through and periodic ALIGNp pairs.
// Optional CONT/junk compression of repeated primitives is enabled by defining SATA_TX_CONT_EN.
//
// state    | meaning
// S_DOWN   | link down or in reset, ALIGNp emitted
// S_RUN    | one primitive or payload dword per slot, slot counter advancing
// S_ALIGN0 | first ALIGNp of the periodic pair
// S_ALIGN1 | second ALIGNp, counter restarts
module sata_link_tx_prim
    import sata_prim_pkg::*;
#(
    parameter int ALIGN_INTERVAL = 256,
    parameter int CNT_W          = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        phy_links_up_in,
    input  logic [3:0]  prim_sel_in,
    input  logic [31:0] tx_data_in,
    input  logic        tx_valid_in,
    output logic        tx_ready_out,
    output logic [31:0] link_data_out,
    output logic [3:0]  link_charisk_out,
    output logic        align_slot_out
);
    typedef enum logic [1:0] {S_DOWN, S_RUN, S_ALIGN0, S_ALIGN1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALIGN_INTERVAL - 3);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    prim_code_t       sel_code;
    logic [31:0]      slot_data;
    logic [3:0]       slot_k;

`ifdef SATA_TX_CONT_EN
    prim_code_t  last_code_q;
    logic        last_ok_q;
    logic [1:0]  run_len_q;
    logic [1:0]  run_len_d;
    logic        junk_adv;
    logic [31:0] junk;

    sata_junk_lfsr u_junk (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .advance (junk_adv),
        .junk    (junk)
    );
`endif

    assign tx_ready_out = (state == S_RUN) && phy_links_up_in && (prim_sel_in == DATA);

    // Payload request without valid data degrades to HOLD.
    always_comb begin
        sel_code = norm_code(prim_sel_in);
        if (sel_code == DATA && !tx_valid_in) begin
            sel_code = HOLD;
        end
        slot_data = prim_dword(sel_code);
        slot_k    = PRIM_K;
        if (sel_code == DATA) begin
            slot_data = tx_data_in;
            slot_k    = 4'b0000;
        end
`ifdef SATA_TX_CONT_EN
        junk_adv  = 1'b0;
        run_len_d = 2'd0;
        if (is_repeatable(sel_code) && last_ok_q && sel_code == last_code_q) begin
            run_len_d = (run_len_q == 2'd3) ? 2'd3 : run_len_q + 2'd1;
        end
        // Third repeat becomes CONT, everything after is scrambling junk.
        if (is_repeatable(sel_code)) begin
            if (run_len_d == 2'd2) begin
                slot_data = PRIM_CONT;
            end else if (run_len_d == 2'd3) begin
                slot_data = junk;
                slot_k    = 4'b0000;
                junk_adv  = (state == S_RUN) && phy_links_up_in;
            end
        end
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !phy_links_up_in) begin
            state            <= S_DOWN;
            cnt              <= '0;
            link_data_out    <= PRIM_ALIGN;
            link_charisk_out <= PRIM_K;
            align_slot_out   <= 1'b1;
`ifdef SATA_TX_CONT_EN
            last_code_q      <= SYNC;
            last_ok_q        <= 1'b0;
            run_len_q        <= 2'd0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    link_data_out    <= slot_data;
                    link_charisk_out <= slot_k;
                    align_slot_out   <= 1'b0;
                    if (cnt == CNT_LAST) begin
                        state <= S_ALIGN0;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
`ifdef SATA_TX_CONT_EN
                    last_code_q <= sel_code;
                    last_ok_q   <= is_repeatable(sel_code);
                    run_len_q   <= run_len_d;
`endif
                end
                S_ALIGN0: begin
                    state            <= S_ALIGN1;
                    link_data_out    <= PRIM_ALIGN;
                    link_charisk_out <= PRIM_K;
                    align_slot_out   <= 1'b1;
                end
                S_ALIGN1: begin
                    state            <= S_RUN;
                    cnt              <= '0;
                    link_data_out    <= PRIM_ALIGN;
                    link_charisk_out <= PRIM_K;
                    align_slot_out   <= 1'b1;
                end
                default: begin
                    state            <= S_RUN;
                    cnt              <= '0;
                    link_data_out    <= PRIM_ALIGN;
                    link_charisk_out <= PRIM_K;
                    align_slot_out   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sata_link_tx_prim.sv
// Self-checking bench for sata_link_tx_prim: directed vector table, multi-cycle sequences, random run.
module tb_sata_link_tx_prim;
    localparam int N = 256;
    localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
    localparam logic [3:0]  SEL_SYNC = 4'd0;
    localparam logic [3:0]  SEL_RIP  = 4'd5;
    localparam logic [3:0]  SEL_ROK  = 4'd6;
    localparam logic [3:0]  SEL_DATA = 4'd11;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        phy_links_up_in;
    logic [3:0]  prim_sel_in;
    logic [31:0] tx_data_in;
    logic        tx_valid_in;
    logic        tx_ready_out;
    logic [31:0] link_data_out;
    logic [3:0]  link_charisk_out;
    logic        align_slot_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: edges since link came up, plus expected registered outputs.
    int          k_slots = 0;
    logic [31:0] exp_d   = ALIGN_DW;
    logic [3:0]  exp_k   = 4'b0001;
    logic        exp_a   = 1'b1;
`ifdef SATA_TX_CONT_EN
    int          prev_code = 0;
    bit          prev_ok   = 1'b0;
    int          run_len   = 0;
    logic [15:0] m_lfsr    = 16'hF0F6;
`endif

    always #5 sys_clk = ~sys_clk;

    sata_link_tx_prim #(.ALIGN_INTERVAL(N), .CNT_W(8)) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .phy_links_up_in  (phy_links_up_in),
        .prim_sel_in      (prim_sel_in),
        .tx_data_in       (tx_data_in),
        .tx_valid_in      (tx_valid_in),
        .tx_ready_out     (tx_ready_out),
        .link_data_out    (link_data_out),
        .link_charisk_out (link_charisk_out),
        .align_slot_out   (align_slot_out)
    );

    typedef struct {
        bit          rst;
        bit          up;
        logic [3:0]  sel;
        logic [31:0] data;
        bit          valid;
        logic [31:0] exp_data;
        logic [3:0]  exp_k;
        bit          exp_align;
        bit          exp_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit up, logic [3:0] sel, logic [31:0] data, bit valid,
                                logic [31:0] ed, logic [3:0] ek, bit ea, bit er);
        vec_t v;
        v.rst = rst; v.up = up; v.sel = sel; v.data = data; v.valid = valid;
        v.exp_data = ed; v.exp_k = ek; v.exp_align = ea; v.exp_ready = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_prim(input int code);
        case (code)
            1:       return 32'hD5D5AA7C;
            2:       return 32'h9595AA7C;
            3:       return 32'h4A4A957C;
            4:       return 32'h5757B57C;
            5:       return 32'h5555B57C;
            6:       return 32'h3535B57C;
            7:       return 32'h5656B57C;
            8:       return 32'h5858B57C;
            9:       return 32'h3737B57C;
            10:      return 32'hD5D5B57C;
            default: return 32'hB5B5957C;
        endcase
    endfunction

`ifdef SATA_TX_CONT_EN
    function automatic logic [15:0] lfsr16(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 16; i++) r = {r[14:0], r[15] ^ r[14] ^ r[12] ^ r[3]};
        return r;
    endfunction
`endif

    // Slot p of each period (counted from the first slot after the link-up ALIGN) is
    // payload/primitive for p < N-2 and ALIGNp for the last two.
    function automatic bit ref_ready(input bit up, input logic [3:0] sel);
        return up && (k_slots >= 1) && (((k_slots - 1) % N) < N - 2) && (sel == SEL_DATA);
    endfunction

    task automatic model_edge(input bit rst, input bit up, input logic [3:0] sel,
                              input logic [31:0] data, input bit valid);
        int code;
        if (rst || !up) begin
            exp_d = ALIGN_DW; exp_k = 4'b0001; exp_a = 1'b1;
            k_slots = 0;
`ifdef SATA_TX_CONT_EN
            prev_ok = 1'b0;
            if (rst) m_lfsr = 16'hF0F6;
`endif
        end else begin
            if (k_slots == 0 || ((k_slots - 1) % N) >= N - 2) begin
                exp_d = ALIGN_DW; exp_k = 4'b0001; exp_a = 1'b1;
            end else if (sel == SEL_DATA && valid) begin
                exp_d = data; exp_k = 4'b0000; exp_a = 1'b0;
`ifdef SATA_TX_CONT_EN
                prev_ok = 1'b0;
`endif
            end else begin
                code  = (sel == SEL_DATA) ? 1 : ((int'(sel) > 11) ? 0 : int'(sel));
                exp_d = ref_prim(code); exp_k = 4'b0001; exp_a = 1'b0;
`ifdef SATA_TX_CONT_EN
                if (code <= 8) begin
                    run_len = (prev_ok && code == prev_code) ? ((run_len < 3) ? run_len + 1 : 3) : 0;
                    prev_code = code;
                    prev_ok   = 1'b1;
                    if (run_len == 2) exp_d = 32'h9999AA7C;
                    else if (run_len == 3) begin
                        exp_d  = {lfsr16(lfsr16(m_lfsr)), lfsr16(m_lfsr)};
                        exp_k  = 4'b0000;
                        m_lfsr = lfsr16(lfsr16(m_lfsr));
                    end
                end else begin
                    prev_ok = 1'b0;
                end
`endif
            end
            k_slots++;
        end
    endtask

    task automatic drive(input bit rst, input bit up, input logic [3:0] sel,
                         input logic [31:0] data, input bit valid);
        sys_rst = rst; phy_links_up_in = up; prim_sel_in = sel; tx_data_in = data; tx_valid_in = valid;
    endtask

    task automatic step(input bit rst, input bit up, input logic [3:0] sel,
                        input logic [31:0] data, input bit valid, output bit rdy);
        drive(rst, up, sel, data, valid);
        #1;
        rdy = tx_ready_out;
        check("tx_ready", {31'd0, tx_ready_out}, {31'd0, ref_ready(up, sel)});
        @(posedge sys_clk);
        model_edge(rst, up, sel, data, valid);
        @(negedge sys_clk);
        check("link_data", link_data_out, exp_d);
        check("link_charisk", {28'd0, link_charisk_out}, {28'd0, exp_k});
        check("align_slot", {31'd0, align_slot_out}, {31'd0, exp_a});
    endtask

    task automatic count_to_align(input logic [3:0] sel, output int n);
        bit r;
        n = 0;
        for (int i = 0; i < 2 * N; i++) begin
            step(1'b0, 1'b1, sel, 32'd0, 1'b0, r);
            if (align_slot_out) break;
            n++;
        end
    endtask

    initial begin
        bit          r;
        int          n;
        logic [31:0] cur;
        logic [31:0] nxt;
        logic [3:0]  rsel;

        drive(1'b1, 1'b0, SEL_SYNC, 32'd0, 1'b0);
        @(posedge sys_clk);
        model_edge(1'b1, 1'b0, SEL_SYNC, 32'd0, 1'b0);
        @(negedge sys_clk);

        vecs.push_back(mk(1, 1, SEL_SYNC, 0, 0, ALIGN_DW, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 1, SEL_SYNC, 0, 0, ALIGN_DW, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 1, 4'd0, 0, 0, 32'hB5B5957C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 4'd1, 0, 0, 32'hD5D5AA7C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 4'd2, 0, 0, 32'h9595AA7C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 4'd3, 0, 0, 32'h4A4A957C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 4'd4, 0, 0, 32'h5757B57C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 4'd5, 0, 0, 32'h5555B57C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 4'd6, 0, 0, 32'h3535B57C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 4'd7, 0, 0, 32'h5656B57C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 4'd8, 0, 0, 32'h5858B57C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 4'd9, 0, 0, 32'h3737B57C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 4'd10, 0, 0, 32'hD5D5B57C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, 4'd13, 0, 0, 32'hB5B5957C, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 1, SEL_DATA, 32'hCAFEF00D, 1, 32'hCAFEF00D, 4'b0000, 0, 1));
        vecs.push_back(mk(0, 1, SEL_DATA, 32'h11111111, 0, 32'hD5D5AA7C, 4'b0001, 0, 1));
        vecs.push_back(mk(0, 0, SEL_DATA, 32'h22222222, 1, ALIGN_DW, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 1, SEL_SYNC, 0, 0, ALIGN_DW, 4'b0001, 1, 0));
        vecs.push_back(mk(0, 1, SEL_DATA, 32'h00001234, 1, 32'h00001234, 4'b0000, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].up, vecs[i].sel, vecs[i].data, vecs[i].valid);
            #1;
            check($sformatf("vec%0d_ready", i), {31'd0, tx_ready_out}, {31'd0, vecs[i].exp_ready});
            @(posedge sys_clk);
            model_edge(vecs[i].rst, vecs[i].up, vecs[i].sel, vecs[i].data, vecs[i].valid);
            @(negedge sys_clk);
            check($sformatf("vec%0d_data", i), link_data_out, vecs[i].exp_data);
            check($sformatf("vec%0d_k", i), {28'd0, link_charisk_out}, {28'd0, vecs[i].exp_k});
            check($sformatf("vec%0d_align", i), {31'd0, align_slot_out}, {31'd0, vecs[i].exp_align});
        end

        // SYNC stream: 254 slots then the ALIGNp pair, period repeats.
        step(1'b1, 1'b0, SEL_SYNC, 0, 0, r);
        step(1'b0, 1'b1, SEL_SYNC, 0, 0, r);
        count_to_align(SEL_SYNC, n);
        check("sync_period1", n, 254);
        step(1'b0, 1'b1, SEL_SYNC, 0, 0, r);
        count_to_align(SEL_SYNC, n);
        check("sync_period2", n, 254);

        // Continuous payload, then payload with valid toggling; order must be preserved.
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b1, 1'b0, SEL_SYNC, 0, 0, r);
            step(1'b0, 1'b1, SEL_SYNC, 0, 0, r);
            cur = 0; nxt = 0;
            for (int i = 0; i < 600; i++) begin
                bit v;
                v = (pass == 0) ? 1'b1 : bit'(i % 2 == 0);
                step(1'b0, 1'b1, SEL_DATA, cur, v, r);
                if (r && v) cur++;
                if (link_charisk_out == 4'b0000 && !align_slot_out) begin
                    check("data_order", link_data_out, nxt);
                    nxt++;
                end
            end
            check("data_count", nxt, cur);
        end

        // Link drop after 100 payload slots, then relink restarts the period.
        step(1'b1, 1'b0, SEL_SYNC, 0, 0, r);
        step(1'b0, 1'b1, SEL_SYNC, 0, 0, r);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, SEL_DATA, i, 1'b1, r);
        drive(1'b0, 1'b0, SEL_DATA, 32'd100, 1'b1);
        #1;
        check("drop_ready_same_cycle", {31'd0, tx_ready_out}, 32'd0);
        step(1'b0, 1'b0, SEL_DATA, 32'd100, 1'b1, r);
        step(1'b0, 1'b1, SEL_SYNC, 0, 0, r);
        count_to_align(SEL_SYNC, n);
        check("relink_period", n, 254);

        // Reset while the FSM sits in S_ALIGN0.
        step(1'b0, 1'b1, SEL_SYNC, 0, 0, r);
        for (int i = 0; i < 254; i++) step(1'b0, 1'b1, SEL_SYNC, 0, 0, r);
        step(1'b1, 1'b1, SEL_DATA, 32'h5, 1'b1, r);
        check("rst_align0_data", link_data_out, ALIGN_DW);
        check("rst_align0_ready", {31'd0, r}, 32'd0);
        step(1'b0, 1'b1, SEL_DATA, 32'h5, 1'b1, r);
        check("post_rst_ready", {31'd0, r}, 32'd0);
        count_to_align(SEL_DATA, n);
        check("post_rst_period", n, 254);

`ifdef SATA_TX_CONT_EN
        begin
            logic [31:0] od[10];
            logic [3:0]  ok[10];
            step(1'b1, 1'b0, SEL_SYNC, 0, 0, r);
            step(1'b0, 1'b1, SEL_SYNC, 0, 0, r);
            for (int i = 0; i < 10; i++) begin
                step(1'b0, 1'b1, SEL_RIP, 0, 0, r);
                od[i] = link_data_out;
                ok[i] = link_charisk_out;
            end
            check("cont_p0", od[0], 32'h5555B57C);
            check("cont_p1", od[1], 32'h5555B57C);
            check("cont_cont", od[2], 32'h9999AA7C);
            for (int i = 3; i < 10; i++) check("cont_junk_k", {28'd0, ok[i]}, 32'd0);
            step(1'b0, 1'b1, SEL_ROK, 0, 0, r);
            check("cont_break", link_data_out, 32'h3535B57C);
        end
`endif

        // Randomized traffic against the reference model.
        step(1'b1, 1'b0, SEL_SYNC, 0, 0, r);
        rsel = SEL_DATA;
        for (int i = 0; i < 4000; i++) begin
            bit rr, uu, vv;
            rr = ($urandom_range(0, 499) == 0);
            uu = ($urandom_range(0, 149) != 0);
            vv = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0)
                rsel = ($urandom_range(0, 1) == 0) ? SEL_DATA : 4'($urandom_range(0, 15));
            step(rr, uu, rsel, $urandom, vv, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sata_link_tx_prim.md
Name: sata_link_tx_prim

Overview:
Link-layer transmit primitive generator; drives the link_data_in/link_charisk_in dword stream that the PHY top forwards to the GTP once phy_links_up_out is high. Encodes link-FSM primitive requests, passes frame payload dwords through a valid/ready handshake, and inserts the mandatory ALIGNp pair at a fixed interval. Emits one registered dword per sys_clk.

Parameters:
ALIGN_INTERVAL, 256, dwords per ALIGN period including the ALIGNp pair; legal 8..256.
CNT_W, 8, width of the ALIGN slot counter; must satisfy 2^CNT_W >= ALIGN_INTERVAL.

Ports:
sys_clk  in  1  transmit user clock (150 MHz)
sys_rst  in  1  synchronous active-high reset
phy_links_up_in  in  1  PHY link-up (from phy_links_up_out)
prim_sel_in  in  4  requested slot content, prim_code_t (SYNC,HOLD,HOLDA,R_RDY,X_RDY,R_IP,R_OK,R_ERR,WTRM,SOF,EOF,DATA)
tx_data_in  in  32  frame payload dword (already scrambled/CRC'd)
tx_valid_in  in  1  tx_data_in valid
tx_ready_out  out  1  payload dword accepted this cycle when tx_valid_in also high
link_data_out  out  32  dword to PHY top link_data_in
link_charisk_out  out  4  K flags to PHY top link_charisk_in
align_slot_out  out  1  registered; high while link_data_out carries ALIGNp

Behaviour:
- Decided: one clock sys_clk; reset sys_rst synchronous, active-high.
- Reset / link down: link_data_out=ALIGNp 32'h7B4A4ABC, link_charisk_out=4'b0001, align_slot_out=1, tx_ready_out=0, slot counter cnt=0, CONT tracking cleared. phy_links_up_in low mid-operation: same state next cycle; tx_ready_out drops combinationally same cycle; no partial pair completion.
- States: S_DOWN, S_RUN, S_ALIGN0, S_ALIGN1. S_DOWN->S_RUN when phy_links_up_in=1 (first RUN slot has cnt=0).
- S_RUN: each slot registers one non-ALIGN dword, cnt++. When a slot is emitted with cnt==ALIGN_INTERVAL-3 (i.e. ALIGN_INTERVAL-2 non-ALIGN dwords done), next state S_ALIGN0 -> S_ALIGN1 -> S_RUN with cnt=0. Period exactly ALIGN_INTERVAL dwords.
- Latency: prim_sel_in/tx_data_in sampled at edge N appear on outputs after edge N (1 cycle).
- Primitive encodings (charisk 0001): SYNC B5B5957C, HOLD D5D5AA7C, HOLDA 9595AA7C, R_RDY 4A4A957C, X_RDY 5757B57C, R_IP 5555B57C, R_OK 3535B57C, R_ERR 5656B57C, WTRM 5858B57C, SOF 3737B57C, EOF D5D5B57C, CONT 9999AA7C. Unused codes -> SYNC.
- DATA: tx_ready_out = state==S_RUN && phy_links_up_in && prim_sel_in==DATA. Handshake: tx_valid&&tx_ready -> tx_data_in output, charisk 0000. DATA with tx_valid_in=0 -> HOLD emitted. tx_ready_out=0 in S_ALIGN0/1 and S_DOWN; upstream holds data.
- Simultaneous: cnt boundary and DATA request -> the DATA dword is accepted in the last RUN slot; the two ALIGN slots follow with tx_ready_out=0.

Optional Feature:
SATA_TX_CONT_EN. Defined: repeatable primitive (SYNC..WTRM) requested in consecutive non-ALIGN slots emits P, P, CONT, then junk dwords (charisk 0000) from LFSR until prim_sel_in changes; ALIGN pairs inside a run do not break it, junk resumes after. SOF/EOF/DATA or a different primitive ends the run; HOLD inserted for tx_valid_in=0 counts as a HOLD request. Not defined: primitives simply repeat, no CONT, no LFSR logic.

Decomposition:
- Package sata_prim_pkg: prim_code_t enum, 32-bit primitive constants, PRIM_K=4'b0001.
- Sub-module sata_junk_lfsr (only under SATA_TX_CONT_EN): 16-bit LFSR, poly x^16+x^15+x^13+x^4+1, seed 16'hF0F6, advance enable, 32-bit output per step; reset on sys_rst.

Test Plan:
- Reset then phy_links_up_in=1, prim_sel=SYNC, ALIGN_INTERVAL=256 -> 254 SYNC (7C/0001 low byte) then 2x 7B4A4ABC, period 256 repeats; align_slot_out matches.
- prim_sel=DATA, tx_valid=1, incrementing data from 0 -> dwords 0..253 out with charisk 0, ready low two cycles during ALIGN, next output 254; no drop/duplicate.
- DATA with tx_valid toggling 1/0 -> HOLD D5D5AA7C in each invalid slot, data order preserved.
- Drop phy_links_up_in at cnt=100 mid-frame -> tx_ready_out 0 same cycle, ALIGN next cycle; relink restarts with cnt=0 (254 dwords before pair).
- sys_rst asserted mid-ALIGN0 -> next cycle ALIGN/0001, ready 0, cnt 0.
- SATA_TX_CONT_EN, R_IP held 10 slots -> R_IP, R_IP, CONT, 7 junk (charisk 0000, LFSR reference match); change to R_OK -> R_OK immediately.
